sfx_sequencer: RTL and testbench

//  Upstream note source for the right channel of the Buzzer stage. It turns one-shot

---
 rtl/sfx_sequencer.sv | 150 +++++++++++++++
 tb/tb_sfx_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_sequencer.sv
// Right-channel note source: plays short multi-note sound effects on game events
// and forwards the background-music divisor while no effect is playing.
module sfx_sequencer #(
    parameter int          CLK_HZ     = 100_000_000,
    parameter int          TICK_HZ    = 100,
    parameter int          NOTE_TICKS = 8,
    parameter int          GAP_TICKS  = 2,
    parameter logic [26:0] SILENT_DIV = 27'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        shoot_sign,
    input  logic        die_evt,
    input  logic [26:0] bg_div,
    output logic [26:0] div_out,
    output logic        busy,
    output logic [1:0]  sfx_id
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TCW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DUR_MAX  = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int DW       = (DUR_MAX > 1) ? $clog2(DUR_MAX + 1) : 1;

    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
    localparam logic [DW-1:0]  NOTE_LAST = DW'(NOTE_TICKS - 1);
    localparam logic [DW-1:0]  GAP_LAST  = DW'(GAP_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;
    typedef enum logic [1:0] {SFX_NONE = 2'd0, SFX_SHOOT = 2'd1, SFX_DIE = 2'd2} sfx_t;

    state_t         state_q, state_d;
    sfx_t           sfx_q, sfx_d;
    logic [1:0]     idx_q, idx_d;
    logic [DW-1:0]  dur_q, dur_d;
    logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
    logic [26:0]    div_q, div_d;
    logic           shoot_q, die_q;
    logic           tick, trig_shoot, trig_die;

    function automatic logic [26:0] rom_note(input sfx_t s, input logic [1:0] i);
        logic [26:0] r;
        r = SILENT_DIV;
        if (s == SFX_SHOOT) begin
            case (i)
                2'd0:    r = 27'd75758;
                2'd1:    r = 27'd63776;
                default: r = 27'd50607;
            endcase
        end else if (s == SFX_DIE) begin
            case (i)
                2'd0:    r = 27'd85034;
                2'd1:    r = 27'd113636;
                2'd2:    r = 27'd151515;
                default: r = 27'd191571;
            endcase
        end
        return r;
    endfunction

    function automatic logic [1:0] last_idx(input sfx_t s);
        return (s == SFX_DIE) ? 2'd3 : 2'd2;
    endfunction

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign trig_shoot = shoot_sign & ~shoot_q;
    assign trig_die   = die_evt & ~die_q;

    always_comb begin
        state_d    = state_q;
        sfx_d      = sfx_q;
        idx_d      = idx_q;
        dur_d      = dur_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        div_d      = div_q;

        case (state_q)
            S_NOTE: begin
                if (tick) begin
                    if (dur_q == NOTE_LAST) begin
                        dur_d = '0;
                        if (idx_q == last_idx(sfx_q)) begin
                            state_d = S_IDLE;
                            sfx_d   = SFX_NONE;
                            idx_d   = 2'd0;
                        end else begin
                            state_d = S_GAP;
                        end
                    end else begin
                        dur_d = dur_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (dur_q == GAP_LAST) begin
                        dur_d   = '0;
                        idx_d   = idx_q + 2'd1;
                        state_d = S_NOTE;
                    end else begin
                        dur_d = dur_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // DIE always wins; SHOOT is dropped while DIE is playing.
        if (trig_die || (trig_shoot && sfx_q != SFX_DIE)) begin
            state_d    = S_NOTE;
            sfx_d      = trig_die ? SFX_DIE : SFX_SHOOT;
            idx_d      = 2'd0;
            dur_d      = '0;
            tick_cnt_d = '0;
        end

        case (state_d)
            S_NOTE:  div_d = rom_note(sfx_d, idx_d);
            S_GAP:   div_d = SILENT_DIV;
            default: div_d = bg_div;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sfx_q      <= SFX_NONE;
            idx_q      <= 2'd0;
            dur_q      <= '0;
            tick_cnt_q <= '0;
            div_q      <= '0;
            shoot_q    <= 1'b1;
            die_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            sfx_q      <= sfx_d;
            idx_q      <= idx_d;
            dur_q      <= dur_d;
            tick_cnt_q <= tick_cnt_d;
            div_q      <= div_d;
            shoot_q    <= shoot_sign;
            die_q      <= die_evt;
        end
    end

    assign div_out = div_q;
    assign busy    = (state_q != S_IDLE);
    assign sfx_id  = sfx_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer: per-cycle expected outputs are queued as
// stimulus is applied and compared one clock at a time.
module tb_sfx_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        shoot_sign;
    logic        die_evt;
    logic [26:0] bg_div;
    logic [26:0] div_out;
    logic        busy;
    logic [1:0]  sfx_id;

    always #5 clk = ~clk;

    sfx_sequencer #(
        .CLK_HZ    (1000),
        .TICK_HZ   (100),
        .NOTE_TICKS(2),
        .GAP_TICKS (1),
        .SILENT_DIV(27'd1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .shoot_sign(shoot_sign),
        .die_evt   (die_evt),
        .bg_div    (bg_div),
        .div_out   (div_out),
        .busy      (busy),
        .sfx_id    (sfx_id)
    );

    typedef struct packed {
        logic [26:0] div;
        logic        busy;
        logic [1:0]  sfx;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    string phase    = "init";

    task automatic chk(input string tag, input logic [26:0] obs, input logic [26:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s/%s cyc %0d: observed %0d expected %0d", phase, tag, cyc, obs, exp);
    endtask

    task automatic push(input logic [26:0] d, input logic b, input logic [1:0] s, input int n);
        exp_t e;
        e.div  = d;
        e.busy = b;
        e.sfx  = s;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic push_shoot();
        push(27'd75758, 1'b1, 2'd1, 20);
        push(27'd1,     1'b1, 2'd1, 10);
        push(27'd63776, 1'b1, 2'd1, 20);
        push(27'd1,     1'b1, 2'd1, 10);
        push(27'd50607, 1'b1, 2'd1, 20);
    endtask

    task automatic push_die();
        push(27'd85034,  1'b1, 2'd2, 20);
        push(27'd1,      1'b1, 2'd2, 10);
        push(27'd113636, 1'b1, 2'd2, 20);
        push(27'd1,      1'b1, 2'd2, 10);
        push(27'd151515, 1'b1, 2'd2, 20);
        push(27'd1,      1'b1, 2'd2, 10);
        push(27'd191571, 1'b1, 2'd2, 20);
    endtask

    task automatic push_idle(input int n);
        push(bg_div, 1'b0, 2'd0, n);
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 27'd1, 27'd0);
            end else begin
                e = sb.pop_front();
                chk("div_out", div_out, e.div);
                chk("busy", {26'd0, busy}, {26'd0, e.busy});
                chk("sfx_id", {25'd0, sfx_id}, {25'd0, e.sfx});
            end
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_div", div_out, 27'd0);
        chk("rst_busy", {26'd0, busy}, 27'd0);
        chk("rst_sfx", {25'd0, sfx_id}, 27'd0);
    endtask

    initial begin
        rst        = 1'b1;
        shoot_sign = 1'b0;
        die_evt    = 1'b0;
        bg_div     = 27'd191571;
        #2;
        phase = "reset";
        chk_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        phase = "idle";
        push_idle(3);
        run(3);
        bg_div = 27'd12345;
        push_idle(2);
        run(2);
        bg_div = 27'd191571;
        push_idle(2);
        run(2);

        phase = "shoot";
        shoot_sign = 1'b1;
        push_shoot();
        push_idle(5);
        run(1);
        shoot_sign = 1'b0;
        run(84);

        phase = "preempt";
        shoot_sign = 1'b1;
        push(27'd75758, 1'b1, 2'd1, 20);
        push(27'd1,     1'b1, 2'd1, 5);
        run(1);
        shoot_sign = 1'b0;
        run(24);
        die_evt = 1'b1;
        push_die();
        push_idle(5);
        run(1);
        die_evt = 1'b0;
        run(114);

        phase = "drop";
        die_evt = 1'b1;
        push_die();
        push_idle(5);
        run(1);
        die_evt = 1'b0;
        run(39);
        shoot_sign = 1'b1;
        run(1);
        shoot_sign = 1'b0;
        run(74);

        phase = "simul";
        shoot_sign = 1'b1;
        die_evt    = 1'b1;
        push_die();
        push_idle(3);
        run(1);
        shoot_sign = 1'b0;
        die_evt    = 1'b0;
        run(112);

        phase = "hold";
        shoot_sign = 1'b1;
        push_shoot();
        push_idle(120);
        run(200);
        shoot_sign = 1'b0;
        push_idle(2);
        run(2);

        phase = "retrig";
        shoot_sign = 1'b1;
        push(27'd75758, 1'b1, 2'd1, 20);
        push(27'd1,     1'b1, 2'd1, 10);
        run(1);
        shoot_sign = 1'b0;
        run(29);
        shoot_sign = 1'b1;
        push_shoot();
        push_idle(3);
        run(1);
        shoot_sign = 1'b0;
        run(82);

        phase = "midreset";
        shoot_sign = 1'b1;
        push(27'd75758, 1'b1, 2'd1, 20);
        push(27'd1,     1'b1, 2'd1, 5);
        run(1);
        shoot_sign = 1'b0;
        run(24);
        #2;
        rst        = 1'b1;
        shoot_sign = 1'b1;
        #1;
        chk_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;
        push_idle(30);
        run(30);
        shoot_sign = 1'b0;
        push_idle(2);
        run(2);

        phase = "end";
        chk("sb_empty", 27'(sb.size()), 27'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
